// File: rtl/regfile_read_arbiter.sv
// Four-requester arbiter for a shared register-file read port: grants one requester, holds its
// select for SETTLE_CYC cycles, then captures the data. Define RDARB_FIXED_PRIO_EN for fixed priority.
module regfile_read_arbiter #(
   parameter int SETTLE_CYC = 1,
   parameter int DW         = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [3:0]    req,
   input  logic [19:0]   addr,
   output logic [4:0]    rd_sel,
   input  logic [DW-1:0] rd_data,
   output logic [3:0]    grant,
   output logic          rsp_valid,
   output logic [1:0]    rsp_id,
   output logic [DW-1:0] rsp_data,
   output logic          busy
);

   if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
      $error("SETTLE_CYC must be in 1..15");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

   state_t        state, state_n;
   logic [3:0]    cnt, cnt_n;
   logic [3:0]    grant_n;
   logic [1:0]    rsp_id_n;
   logic [4:0]    rd_sel_n;
   logic          rsp_valid_n;
   logic [DW-1:0] rsp_data_n;
   logic [3:0]    elig;
   logic [1:0]    win;
   logic [4:0]    req_addr [4];

   for (genvar i = 0; i < 4; i++) begin : g_addr
      assign req_addr[i] = addr[5*i +: 5];
   end

   function automatic logic [3:0] onehot(input logic [1:0] idx);
      onehot = 4'b0001 << idx;
   endfunction

`ifdef RDARB_FIXED_PRIO_EN
   // Lowest index wins; scanning downward leaves the lowest set bit.
   function automatic logic [1:0] pick(input logic [3:0] e);
      pick = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (e[k]) pick = 2'(k);
      end
   endfunction

   assign win = pick(elig);
`else
   logic [1:0] last, last_n;

   // Scan starts just after the last winner; k=4 wraps back onto the last winner itself.
   function automatic logic [1:0] pick(input logic [3:0] e, input logic [1:0] prev);
      logic [1:0] idx;
      logic       found;
      pick  = prev;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = prev + 2'(k);
         if (!found && e[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   endfunction

   assign win = pick(elig, last);
`endif

   // The requester just served is masked for the response cycle so a still-held req is not re-granted.
   assign elig = req & ~(rsp_valid ? onehot(rsp_id) : 4'b0000);
   assign busy = (state != IDLE);

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      grant_n     = grant;
      rsp_id_n    = rsp_id;
      rd_sel_n    = rd_sel;
      rsp_valid_n = 1'b0;
      rsp_data_n  = rsp_data;
`ifndef RDARB_FIXED_PRIO_EN
      last_n      = last;
`endif
      unique case (state)
         IDLE: begin
            if (|elig) begin
               grant_n  = onehot(win);
               rsp_id_n = win;
               rd_sel_n = req_addr[win];
               cnt_n    = CNT_LOAD;
               state_n  = SETTLE;
`ifndef RDARB_FIXED_PRIO_EN
               last_n   = win;
`endif
            end
         end
         SETTLE: begin
            if (cnt == 4'd0) state_n = CAPTURE;
            else             cnt_n   = cnt - 4'd1;
         end
         CAPTURE: begin
            rsp_data_n  = rd_data;
            rsp_valid_n = 1'b1;
            grant_n     = 4'b0000;
            state_n     = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         grant     <= 4'b0000;
         rsp_id    <= 2'd0;
         rd_sel    <= 5'd0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
`ifndef RDARB_FIXED_PRIO_EN
         last      <= 2'd3;
`endif
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         grant     <= grant_n;
         rsp_id    <= rsp_id_n;
         rd_sel    <= rd_sel_n;
         rsp_valid <= rsp_valid_n;
         rsp_data  <= rsp_data_n;
`ifndef RDARB_FIXED_PRIO_EN
         last      <= last_n;
`endif
      end
   end

   a_grant_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
   a_busy_grant   : assert property (@(posedge clk) disable iff (reset) busy == (|grant));
   a_rsp_idle     : assert property (@(posedge clk) disable iff (reset) rsp_valid |-> !busy);

endmodule
